seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, the next generation of the single-bit `x`→`z` sequence FSM used in the lab exercises. It samples a 1-bit serial stream on every enabled clock edge and pulses `z` when the last `N` sampled bits equal a runtime-loadable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial input source and downstream logic or LEDs that consume a registered single-cycle match strobe.

## Interface

- `N`, default 4: pattern length in bits, N ≥ 2.
- `PATTERN`, default 4'b1011: reset value of the pattern register, N bits, MSB compared against the oldest sampled bit.
- `CNT_W`, default 8: match counter width.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: sample enable; `x` is consumed only on edges where `en`=1.
- `x`, input, 1: serial data bit.
- `overlap`, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- `load`, input, 1: load `pattern` into the pattern register.
- `pattern`, input, N: new pattern value, used only when `load`=1.
- `clr_cnt`, input, 1: synchronous clear of `match_cnt`.
- `z`, output, 1: registered match pulse.
- `match_cnt`, output, CNT_W: saturating count of matches.

## Operation

- State: `pat_reg` (N bits), `hist` (N-bit shift register, newest bit in LSB), `fill` (0..N, number of valid bits in `hist`), `z`, `match_cnt`.
- Reset (`rst`=0, asynchronous, no clock needed): `pat_reg`=PATTERN, `hist`=0, `fill`=0, `z`=0, `match_cnt`=0.
- Edge priority, highest first: `load`, then `en`, then idle.
- `load`=1: `pat_reg`←`pattern`, `hist`←0, `fill`←0, `z`←0. `x` is not sampled on that edge. `match_cnt` is unaffected except by `clr_cnt`.
- `en`=1, `load`=0: `hist_next`={`hist`[N-2:0], `x`}, `fill_next`=min(`fill`+1, N).
  - match = (`fill_next`==N) and (`hist_next`==`pat_reg`).
  - `z`←match.
  - If match and `overlap`=0: `fill`←0, so a new match needs N fresh bits. Otherwise `fill`←`fill_next`. `hist`←`hist_next` in both cases.
- `en`=0, `load`=0: `hist` and `fill` hold, `z`←0. A gap in `en` does not break a partial match.
- `match_cnt`:
  - `clr_cnt`=1 → 0. Clear wins over a simultaneous match.
  - Else on match → +1, saturating at 2^CNT_W−1, with no wrap.
- `overlap` is sampled every edge. Changing it mid-stream affects only the next match.
- There is no explicit FSM encoding. The state is the (`fill`, `hist`) pair, so every pattern, including self-overlapping ones such as 1111 or 1010, is detected correctly without pattern-specific transitions.

## Timing

- Latency: `z` is high for exactly one cycle, starting at the rising edge that samples the N-th matching bit. It is registered, so there is no combinational path from `x` to `z`.
- Back-to-back matches are allowed. With `overlap`=1, `z` can stay high on consecutive cycles. With `overlap`=0, consecutive `z` pulses are at least N sampled bits apart.
- `match_cnt` updates on the same edge as `z`.
- The first possible match comes N enabled edges after reset or `load`.
- If `rst` is asserted mid-stream, all outputs clear immediately. Detection restarts with `fill`=0 on the first enabled edge after `rst` is released.

## Test plan

- Default pattern 1011, `overlap`=1, `en`=1, stream 1,0,1,1,0,1,1 → `z` high after the 4th and 7th edges only; `match_cnt`=2.
- Same stream with `overlap`=0 → `z` high after the 4th edge only; `match_cnt`=1.
- `load`=1 with `pattern`=1111, then stream 1,1,1,1,1,1 with `overlap`=1 → `z` high after edges 4, 5 and 6; `match_cnt`=3. Repeat with `overlap`=0 → `z` high after edge 4 only.
- Stream 1,0,1,1 with `en`=0 for 3 cycles between the 2nd and 3rd bits → a single `z` pulse after the 4th enabled edge; `z`=0 during the gap.
- `CNT_W`=2, 5 matches with `overlap`=1 → `match_cnt` sticks at 3. `clr_cnt` on the same edge as a match → `match_cnt`=0.
- Drive `rst` low between clock edges after 3 bits of 1011 plus 2 prior matches → `z`=0 and `match_cnt`=0 immediately. After release, the remaining bit 1 alone → no `z`.

Source files
------------

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parametrised serial pattern detector. Samples a 1-bit stream
//               on enabled edges and emits a registered one-cycle strobe when
//               the last N sampled bits equal a runtime-loadable pattern.
//               Supports overlapping / non-overlapping detection and keeps a
//               saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pattern,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    // Fill counter must hold the values 0..N inclusive.
    localparam int                  c_FILL_W    = $clog2(N + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(N);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    logic [N-1:0]        r_pat;
    logic [N-1:0]        r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_z;
    logic [CNT_W-1:0]    r_cnt;

    logic [N-1:0]        w_hist_next;
    logic [c_FILL_W-1:0] w_fill_next;
    logic                w_match;

    // Next history/fill values and the match decision for this edge.
    // A load edge never samples x, so it can never produce a match.
    always_comb begin
        w_hist_next = {r_hist[N-2:0], x};
        w_fill_next = (r_fill == c_FILL_FULL) ? c_FILL_FULL : (r_fill + c_FILL_ONE);
        w_match     = en && !load
                      && (w_fill_next == c_FILL_FULL)
                      && (w_hist_next == r_pat);
    end

    // Pattern register, history shift register and fill level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else if (load) begin
            r_pat  <= pattern;
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= w_hist_next;
            // Non-overlapping mode discards the matched bits so the next hit
            // needs N fresh samples; the history itself still shifts.
            r_fill <= (w_match && !overlap) ? '0 : w_fill_next;
        end
    end

    // Registered match strobe: high only on the edge that completes a match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_match;
        end
    end

    // Saturating match counter; a clear beats a simultaneous match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign z         = r_z;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Self-checking bench for seq_detect_param. A table of
//               {inputs, expected outputs} records plus hand-written
//               sequences; expected values are queued when stimulus is
//               driven and popped when the DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    typedef struct {
        bit         en;
        bit         x;
        bit         ov;
        bit         ld;
        logic [3:0] pat;
        bit         clr;
        bit         ez;
        logic [7:0] ecnt;
    } vec_t;

    typedef struct {
        bit         z;
        logic [7:0] cnt;
        int         idx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       overlap;
    logic       load;
    logic [3:0] pattern;
    logic       clr_cnt;
    logic       z;
    logic [7:0] match_cnt;

    int   n_pass;
    int   n_total;
    int   step_idx;
    vec_t tbl[$];
    exp_t exp_q[$];

    seq_detect_param #(
        .N       (4),
        .PATTERN (4'b1011),
        .CNT_W   (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .overlap   (overlap),
        .load      (load),
        .pattern   (pattern),
        .clr_cnt   (clr_cnt),
        .z         (z),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic void add(bit ven, bit vx, bit vov, bit vld, logic [3:0] vpat,
                                bit vclr, bit vez, int vecnt);
        vec_t v;
        v.en   = ven;
        v.x    = vx;
        v.ov   = vov;
        v.ld   = vld;
        v.pat  = vpat;
        v.clr  = vclr;
        v.ez   = vez;
        v.ecnt = 8'(vecnt);
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic got_z, input logic [7:0] got_cnt,
                         input bit exp_z, input logic [7:0] exp_cnt);
        n_total++;
        if (got_z === exp_z && got_cnt === exp_cnt) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got z=%0b cnt=%0d, expected z=%0b cnt=%0d",
                     name, got_z, got_cnt, exp_z, exp_cnt);
        end
    endtask

    // Drive one vector at the falling edge, queue its expectation, then
    // sample the DUT just after the rising edge and compare.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        en      = v.en;
        x       = v.x;
        overlap = v.ov;
        load    = v.ld;
        pattern = v.pat;
        clr_cnt = v.clr;
        e.z     = v.ez;
        e.cnt   = v.ecnt;
        e.idx   = step_idx;
        exp_q.push_back(e);
        step_idx++;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: got empty queue, required an entry");
        end else begin
            e = exp_q.pop_front();
            check($sformatf("step[%0d]", e.idx), z, match_cnt, e.z, e.cnt);
        end
    endtask

    task automatic s(bit ven, bit vx, bit vov, bit vld, logic [3:0] vpat,
                     bit vclr, bit vez, int vecnt);
        vec_t v;
        v.en = ven; v.x = vx; v.ov = vov; v.ld = vld; v.pat = vpat;
        v.clr = vclr; v.ez = vez; v.ecnt = 8'(vecnt);
        step(v);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        step_idx = 0;

        // ---- vector table:      en x  ov ld pat      clr ez cnt
        // 1011 overlapping: hits after edges 4 and 7
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        add(1, 0, 1, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 2);
        // restart via load, 1011 non-overlapping: hit after edge 4 only
        add(0, 0, 0, 1, 4'b1011, 0, 0, 2);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 2);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 2);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 2);
        add(1, 1, 0, 0, 4'b0000, 0, 1, 3);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 3);
        add(0, 0, 0, 0, 4'b0000, 1, 0, 0);
        // 1111 overlapping: hits after edges 4, 5, 6
        add(0, 0, 1, 1, 4'b1111, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 2);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 3);
        // 1111 non-overlapping: hit after edge 4 only
        add(0, 0, 0, 1, 4'b1111, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 3);
        add(1, 1, 0, 0, 4'b0000, 0, 1, 4);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 4);
        add(1, 1, 0, 0, 4'b0000, 0, 0, 4);
        add(0, 0, 0, 0, 4'b0000, 1, 0, 0);
        // en gap inside a partial 1011 match (x toggling while disabled)
        add(0, 0, 1, 1, 4'b1011, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        // clear on the same edge as a match: z still pulses, count -> 0
        add(1, 0, 1, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 1, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 1, 0, 4'b0000, 1, 1, 0);
        add(0, 0, 1, 0, 4'b0000, 0, 0, 0);

        // Reset state, checked before any clock edge.
        rst     = 1'b0;
        en      = 1'b0;
        x       = 1'b0;
        overlap = 1'b1;
        load    = 1'b0;
        pattern = 4'b0000;
        clr_cnt = 1'b0;
        #2;
        check("reset_state", z, match_cnt, 1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Saturation: 1111 overlapping matches from edge 4 on, count caps at 255.
        s(0, 0, 1, 1, 4'b1111, 0, 0, 0);
        for (int k = 1; k <= 262; k++) begin
            int m;
            m = (k >= 4) ? k - 3 : 0;
            if (m > 255) m = 255;
            s(1, 1, 1, 0, 4'b0000, 0, (k >= 4), m);
        end
        s(0, 0, 1, 0, 4'b0000, 1, 0, 0);

        // Two matches, then 3 bits of a partial 1011, then async reset.
        s(0, 0, 1, 1, 4'b1011, 0, 0, 0);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        s(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        s(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        s(1, 0, 1, 0, 4'b0000, 0, 0, 1);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 1);
        s(1, 1, 1, 0, 4'b0000, 0, 1, 2);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 2);
        s(1, 0, 1, 0, 4'b0000, 0, 0, 2);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_midstream", z, match_cnt, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        // Remaining bit alone must not complete a match after reset.
        s(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        // Detection restarts cleanly from the reset-value pattern.
        s(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        s(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        s(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        // Async reset while z is high clears it without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_z_high", z, match_cnt, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        s(0, 0, 1, 0, 4'b0000, 0, 0, 0);

        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
